// File: rtl/ethernet_pkg.sv
// Shared types and constants for the RMII Ethernet receive/transmit path.
// Holds the receiver state encoding, framing dibits, CRC-32 constants and frame length limits.
package ethernet_pkg;

    typedef enum logic [2:0] {
        DRAIN,
        IDLE,
        PREAMBLE,
        BODY,
        CHECK
    } rx_state_t;

    localparam logic [1:0]  PREAMBLE_DIBIT   = 2'b01;
    localparam logic [1:0]  SFD_DIBIT        = 2'b11;

    localparam logic [31:0] CRC_POLY         = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT         = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE      = 32'hDEBB20E3;

    localparam logic [12:0] MIN_FRAME_DIBITS = 13'd256;
    localparam logic [12:0] MAX_FRAME_DIBITS = 13'd6072;

    localparam logic [7:0]  RW_READ          = 8'h00;
    localparam logic [7:0]  RW_WRITE         = 8'h01;

    // One step of the reflected CRC-32 shift register for a single input bit.
    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        crc_bit = (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? CRC_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Registered reflected CRC-32 that consumes one RMII dibit per enabled cycle, d[0] first.
// No final inversion: a frame including its FCS leaves CRC_RESIDUE in the register.
module crc32_dibit
    import ethernet_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [1:0]  d,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_bit(crc_bit(crc, d[0]), d[1]);
        end
    end

endmodule

// File: rtl/ethernet_rx.sv
// RMII receive front-end: decodes one filtered, FCS-checked Ethernet frame into a
// single bus transaction (rw, addr, data) with a one-cycle valid pulse.
module ethernet_rx
    import ethernet_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC  = 48'h69_69_5A_06_54_91,
    parameter logic [15:0] ETHERTYPE = 16'h88_B5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crsdv,
    input  logic [1:0]  rxd,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o,
    output logic        crc_err_o
);

    rx_state_t   state;
    rx_state_t   state_next;

    logic [4:0]  pre_cnt;
    logic [12:0] dibit_cnt;
    logic [15:0] shift_reg;
    logic        drop;
    logic        rw_tmp;
    logic [15:0] addr_tmp;
    logic [15:0] data_tmp;
    logic [31:0] crc;

    logic        sfd_hit;
    logic        crc_en;
    logic [15:0] shift_next;
    logic        byte_done;
    logic [10:0] byte_idx;
    logic [7:0]  cur_byte;
    logic [7:0]  prev_byte;
    logic        byte_bad;
    logic [12:0] cnt_inc;
    logic        oversize;
    logic        len_ok;
    logic        frame_good;

    crc32_dibit u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sfd_hit),
        .en    (crc_en),
        .d     (rxd),
        .crc   (crc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DRAIN;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits out any frame already in flight so a mid-frame reset release never false-syncs.
    always_comb begin
        state_next = state;
        sfd_hit    = 1'b0;
        case (state)
            DRAIN: begin
                if (!crsdv) state_next = IDLE;
            end
            IDLE: begin
                if (crsdv) begin
                    if (rxd == PREAMBLE_DIBIT)  state_next = PREAMBLE;
                    else if (rxd != 2'b00)      state_next = DRAIN;
                end
            end
            PREAMBLE: begin
                if (crsdv && rxd == PREAMBLE_DIBIT) begin
                    state_next = PREAMBLE;
                end else if (crsdv && rxd == SFD_DIBIT && pre_cnt >= 5'd4) begin
                    sfd_hit    = 1'b1;
                    state_next = BODY;
                end else begin
                    state_next = DRAIN;
                end
            end
            BODY: begin
                if (!crsdv) state_next = CHECK;
            end
            CHECK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = DRAIN;
            end
        endcase
    end

    assign crc_en     = (state == BODY) && crsdv;
    assign shift_next = {rxd, shift_reg[15:2]};
    assign byte_done  = (dibit_cnt[1:0] == 2'b11);
    assign byte_idx   = dibit_cnt[12:2];
    assign cur_byte   = shift_next[15:8];
    assign prev_byte  = shift_next[7:0];
    assign cnt_inc    = (dibit_cnt == 13'h1FFF) ? dibit_cnt : dibit_cnt + 13'd1;
    assign oversize   = (cnt_inc > MAX_FRAME_DIBITS);
    assign len_ok     = (dibit_cnt >= MIN_FRAME_DIBITS) && (dibit_cnt[1:0] == 2'b00);
    assign frame_good = !drop && len_ok && (crc == CRC_RESIDUE);

    // Header filter, evaluated on the dibit that completes each byte.
    always_comb begin
        byte_bad = 1'b0;
        if (byte_done) begin
            case (byte_idx)
                11'd0:   byte_bad = (cur_byte != FPGA_MAC[47:40]);
                11'd1:   byte_bad = (cur_byte != FPGA_MAC[39:32]);
                11'd2:   byte_bad = (cur_byte != FPGA_MAC[31:24]);
                11'd3:   byte_bad = (cur_byte != FPGA_MAC[23:16]);
                11'd4:   byte_bad = (cur_byte != FPGA_MAC[15:8]);
                11'd5:   byte_bad = (cur_byte != FPGA_MAC[7:0]);
                11'd12:  byte_bad = (cur_byte != ETHERTYPE[15:8]);
                11'd13:  byte_bad = (cur_byte != ETHERTYPE[7:0]);
                11'd14:  byte_bad = !((cur_byte == RW_READ) || (cur_byte == RW_WRITE));
                default: byte_bad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            dibit_cnt <= '0;
            shift_reg <= '0;
            drop      <= 1'b0;
            rw_tmp    <= 1'b0;
            addr_tmp  <= '0;
            data_tmp  <= '0;
            addr_o    <= '0;
            data_o    <= '0;
            rw_o      <= 1'b0;
            valid_o   <= 1'b0;
            crc_err_o <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            crc_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (crsdv && rxd == PREAMBLE_DIBIT) pre_cnt <= 5'd1;
                end
                PREAMBLE: begin
                    if (crsdv && rxd == PREAMBLE_DIBIT && pre_cnt != 5'd31) pre_cnt <= pre_cnt + 5'd1;
                    if (sfd_hit) begin
                        dibit_cnt <= '0;
                        shift_reg <= '0;
                        drop      <= 1'b0;
                    end
                end
                BODY: begin
                    if (crsdv) begin
                        shift_reg <= shift_next;
                        dibit_cnt <= cnt_inc;
                        if (byte_bad || oversize) drop <= 1'b1;
                        if (byte_done && byte_idx == 11'd14) rw_tmp   <= cur_byte[0];
                        if (byte_done && byte_idx == 11'd16) addr_tmp <= {prev_byte, cur_byte};
                        if (byte_done && byte_idx == 11'd18) data_tmp <= {prev_byte, cur_byte};
                    end
                end
                CHECK: begin
                    if (frame_good) begin
                        addr_o  <= addr_tmp;
                        rw_o    <= rw_tmp;
                        if (rw_tmp) data_o <= data_tmp;
                        valid_o <= 1'b1;
                    end else if (!drop && len_ok) begin
                        crc_err_o <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_rx.sv
// Randomized self-checking bench for ethernet_rx: frames are built byte-wise with a
// software CRC and the expected bus outcome is derived from the frame contents.
module tb_ethernet_rx;

    localparam logic [47:0] MAC   = 48'h69695A065491;
    localparam logic [15:0] ETYPE = 16'h88B5;

    logic        clk;
    logic        rst_n;
    logic        crsdv;
    logic [1:0]  rxd;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;
    logic        crc_err_o;

    int check_count = 0;
    int pass_count  = 0;
    int valid_count = 0;
    int err_count   = 0;

    logic [7:0]  frame_q[$];
    logic [15:0] m_addr = '0;
    logic [15:0] m_data = '0;
    logic        m_rw   = 1'b0;

    ethernet_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .crsdv     (crsdv),
        .rxd       (rxd),
        .addr_o    (addr_o),
        .data_o    (data_o),
        .rw_o      (rw_o),
        .valid_o   (valid_o),
        .crc_err_o (crc_err_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (valid_o)   valid_count++;
        if (crc_err_o) err_count++;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Standard byte-wise Ethernet FCS (complemented) over the first n bytes of frame_q.
    function automatic logic [31:0] crcOf(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frame_q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic buildFrame(input logic [47:0] dst, input logic [15:0] etype, input logic [7:0] rwb,
                              input logic [15:0] a, input logic [15:0] d, input int pad);
        frame_q.delete();
        for (int i = 5; i >= 0; i--) frame_q.push_back(dst[8*i +: 8]);
        for (int i = 0; i < 6; i++)  frame_q.push_back(8'($urandom));
        frame_q.push_back(etype[15:8]);
        frame_q.push_back(etype[7:0]);
        frame_q.push_back(rwb);
        frame_q.push_back(a[15:8]);
        frame_q.push_back(a[7:0]);
        frame_q.push_back(d[15:8]);
        frame_q.push_back(d[7:0]);
        for (int i = 0; i < pad; i++) frame_q.push_back(8'($urandom));
    endtask

    task automatic appendFcs();
        logic [31:0] fcs;
        fcs = crcOf(frame_q.size());
        for (int i = 0; i < 4; i++) frame_q.push_back(fcs[8*i +: 8]);
    endtask

    // Reference outcome from the frame contents, and update of the expected output registers.
    task automatic modelFrame(input int pre_len, input bit was_reset, output logic exp_valid, output logic exp_err);
        int          n;
        bit          hdr_ok;
        logic [31:0] fcs_rx;
        n         = frame_q.size();
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (was_reset) begin
            m_addr = '0;
            m_data = '0;
            m_rw   = 1'b0;
        end else if (pre_len >= 4 && n >= 64 && n <= 1518) begin
            hdr_ok = ({frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]} == MAC)
                  && ({frame_q[12], frame_q[13]} == ETYPE)
                  && (frame_q[14] == 8'h00 || frame_q[14] == 8'h01);
            fcs_rx = {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]};
            if (hdr_ok) begin
                if (crcOf(n - 4) == fcs_rx) begin
                    exp_valid = 1'b1;
                    m_addr    = {frame_q[15], frame_q[16]};
                    m_rw      = frame_q[14][0];
                    if (m_rw) m_data = {frame_q[17], frame_q[18]};
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input int pre_len, input int ipg, input int reset_byte);
        logic       exp_valid;
        logic       exp_err;
        int         v0;
        int         e0;
        logic [7:0] b;
        modelFrame(pre_len, reset_byte >= 0, exp_valid, exp_err);
        v0 = valid_count;
        e0 = err_count;
        for (int i = 0; i < pre_len; i++) begin
            @(negedge clk); crsdv = 1'b1; rxd = 2'b01;
        end
        @(negedge clk); crsdv = 1'b1; rxd = 2'b11;
        for (int i = 0; i < frame_q.size(); i++) begin
            b = frame_q[i];
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                crsdv = 1'b1;
                rxd   = b[2*k +: 2];
                rst_n = !(i == reset_byte && k == 0);
            end
        end
        @(negedge clk); crsdv = 1'b0; rxd = 2'b00; rst_n = 1'b1;
        @(negedge clk);
        checkOutput("valid_early", {31'h0, valid_o}, 32'h0);
        @(negedge clk);
        checkOutput("valid_pulse", {31'h0, valid_o}, {31'h0, exp_valid});
        checkOutput("crc_err_pulse", {31'h0, crc_err_o}, {31'h0, exp_err});
        checkOutput("addr_o", {16'h0, addr_o}, {16'h0, m_addr});
        checkOutput("data_o", {16'h0, data_o}, {16'h0, m_data});
        checkOutput("rw_o", {31'h0, rw_o}, {31'h0, m_rw});
        @(negedge clk);
        checkOutput("pulse_end", {30'h0, valid_o, crc_err_o}, 32'h0);
        for (int i = 4; i < ipg; i++) @(negedge clk);
        checkOutput("valid_count", 32'(valid_count - v0), {31'h0, exp_valid});
        checkOutput("err_count", 32'(err_count - e0), {31'h0, exp_err});
    endtask

    initial begin
        int          kind;
        int          idx;
        logic [15:0] ra;
        logic [15:0] rd;
        logic [7:0]  rwb;

        rst_n = 1'b0;
        crsdv = 1'b0;
        rxd   = 2'b00;
        repeat (4) @(negedge clk);
        checkOutput("reset_addr", {16'h0, addr_o}, 32'h0);
        checkOutput("reset_data", {16'h0, data_o}, 32'h0);
        checkOutput("reset_rw", {31'h0, rw_o}, 32'h0);
        checkOutput("reset_valid", {31'h0, valid_o}, 32'h0);
        checkOutput("reset_crc_err", {31'h0, crc_err_o}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        buildFrame(MAC, ETYPE, 8'h01, 16'h1234, 16'h6970, 41); appendFcs();
        applyStimulus(28, 48, -1);
        buildFrame(MAC, ETYPE, 8'h00, 16'h0042, 16'hBEEF, 41); appendFcs();
        applyStimulus(28, 48, -1);

        buildFrame(48'h00E04C681E0C, ETYPE, 8'h01, 16'h0100, 16'h0200, 41); appendFcs();
        applyStimulus(28, 48, -1);
        buildFrame(MAC, 16'h0800, 8'h01, 16'h0101, 16'h0202, 41); appendFcs();
        applyStimulus(28, 48, -1);
        buildFrame(MAC, ETYPE, 8'h02, 16'h0102, 16'h0203, 41); appendFcs();
        applyStimulus(28, 48, -1);

        buildFrame(MAC, ETYPE, 8'h01, 16'h7777, 16'h8888, 41); appendFcs();
        frame_q[frame_q.size() - 4] = frame_q[frame_q.size() - 4] ^ 8'h01;
        applyStimulus(28, 48, -1);

        buildFrame(MAC, ETYPE, 8'h01, 16'h3333, 16'h4444, 41); appendFcs();
        while (frame_q.size() > 40) void'(frame_q.pop_back());
        applyStimulus(28, 48, -1);
        buildFrame(MAC, ETYPE, 8'h01, 16'h5555, 16'h6666, 41); appendFcs();
        applyStimulus(28, 48, 20);
        buildFrame(MAC, ETYPE, 8'h01, 16'h0001, 16'h0002, 41); appendFcs();
        applyStimulus(28, 48, -1);

        buildFrame(MAC, ETYPE, 8'h01, 16'h0010, 16'hAAAA, 41); appendFcs();
        applyStimulus(28, 48, -1);
        buildFrame(MAC, ETYPE, 8'h01, 16'h0011, 16'h5555, 41); appendFcs();
        applyStimulus(28, 48, -1);

        buildFrame(MAC, ETYPE, 8'h01, 16'h0A0A, 16'h0B0B, 41); appendFcs();
        applyStimulus(3, 48, -1);
        buildFrame(MAC, ETYPE, 8'h01, 16'h0C0C, 16'h0D0D, 41); appendFcs();
        applyStimulus(4, 48, -1);
        buildFrame(MAC, ETYPE, 8'h01, 16'h1518, 16'h1518, 1496); appendFcs();
        applyStimulus(28, 48, -1);
        buildFrame(MAC, ETYPE, 8'h01, 16'h1519, 16'h1519, 1497); appendFcs();
        applyStimulus(28, 48, -1);

        for (int f = 0; f < 24; f++) begin
            kind = $urandom_range(0, 6);
            ra   = 16'($urandom);
            rd   = 16'($urandom);
            rwb  = 8'($urandom_range(0, 1));
            buildFrame(MAC, ETYPE, rwb, ra, rd, $urandom_range(41, 60));
            case (kind)
                3: begin
                    idx = $urandom_range(0, 5);
                    frame_q[idx] = frame_q[idx] ^ 8'($urandom_range(1, 255));
                end
                4: begin
                    idx = $urandom_range(12, 13);
                    frame_q[idx] = frame_q[idx] ^ 8'($urandom_range(1, 255));
                end
                5: frame_q[14] = 8'($urandom_range(2, 255));
                default: begin
                end
            endcase
            appendFcs();
            if (kind == 6) begin
                idx = $urandom_range(0, frame_q.size() - 1);
                frame_q[idx] = frame_q[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
            applyStimulus($urandom_range(4, 31), $urandom_range(48, 80), -1);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
